// File: rtl/pc_fetch_unit.sv
// PC register, IF->ID->EX delay pipe and EX branch resolution with a 2-slot squash.
// Optional BRANCH_NE_EN adds a BNE opcode that redirects on unequal operands.
module pc_fetch_unit #(
    parameter int PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int PC_INC = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic [5:0]          opcode_ex,
    input  logic [31:0]         rs1_value,
    input  logic [31:0]         rs2_value,
    input  logic [PC_WIDTH-1:0] target_addr,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_delay,
    output logic                ex_valid,
    output logic                branch_taken,
    output logic                flush
);

    localparam logic [5:0] OP_JUMP = 6'b010101;
    localparam logic [5:0] OP_BRA  = 6'b010110;
`ifdef BRANCH_NE_EN
    localparam logic [5:0] OP_BNE  = 6'b010111;
`endif

    typedef enum logic {RUN, FLUSH} state_t;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic                valid;
    } slot_t;

    state_t              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [PC_WIDTH-1:0] pc_q;
    slot_t               id_q, ex_q;
    logic                ops_eq;
    logic                cond;
    logic                redirect;

    assign ops_eq = (rs1_value == rs2_value);

    always_comb begin
        cond = 1'b0;
        unique case (1'b1)
            opcode_ex == OP_JUMP: cond = 1'b1;
            opcode_ex == OP_BRA:  cond = ops_eq;
`ifdef BRANCH_NE_EN
            opcode_ex == OP_BNE:  cond = !ops_eq;
`endif
            default:              cond = 1'b0;
        endcase
    end

    assign redirect     = ex_q.valid && !stall && cond;
    assign branch_taken = redirect;
    assign pc           = pc_q;
    assign pc_delay     = ex_q.pc;
    assign ex_valid     = ex_q.valid;
    assign flush        = (state_q == FLUSH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
            id_q <= '0;
            ex_q <= '0;
        end else if (!stall) begin
            id_q.pc <= pc_q;
            ex_q.pc <= id_q.pc;
            if (redirect) begin
                pc_q       <= target_addr;
                id_q.valid <= 1'b0;
                ex_q.valid <= 1'b0;
            end else begin
                pc_q       <= pc_q + PC_WIDTH'(PC_INC);
                id_q.valid <= 1'b1;
                ex_q.valid <= id_q.valid;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Squash counter covers the two wrong-path slots behind a redirect.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (redirect) begin
                    state_d = FLUSH;
                    cnt_d   = 2'd2;
                end
            end
            FLUSH: begin
                if (!stall) begin
                    cnt_d = cnt_q - 2'd1;
                    if (cnt_q == 2'd1)
                        state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 2'd0;
            end
        endcase
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and fetch-address stage directly upstream of branch_program.
- Owns the PC and carries each fetched PC down a two-deep delay pipe (IF→ID→EX). Supplies the delayed PC to branch_program as pc_delay.
- Resolves branches in EX: compares the register operands, and on a taken BRA or JUMP redirects the PC to branch_program's pc_add_imme. After a redirect it squashes the two wrong-path instructions.

Parameters:
- PC_WIDTH, 32, width of all PC/address buses.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_INC, 4, sequential PC increment (byte-addressed 32-bit instructions).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  freeze PC, delay pipe and state.
- opcode_ex  input  6  opcode of the instruction in EX.
- rs1_value  input  32  rs1 operand of the EX instruction.
- rs2_value  input  32  rs2 operand of the EX instruction.
- target_addr  input  PC_WIDTH  branch/jump target; connect to branch_program pc_add_imme.
- pc  output  PC_WIDTH  current fetch address.
- pc_delay  output  PC_WIDTH  PC of the EX instruction; connect to branch_program pc_delay.
- ex_valid  output  1  EX instruction is valid (not a bubble or squashed).
- branch_taken  output  1  redirect this cycle.
- flush  output  1  high while wrong-path slots are being squashed.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port reset.
- Opcodes: JUMP = 6'b010101, BRA = 6'b010110.
- Reset values: pc=RESET_PC, pc_id=0, pc_delay=0, id_valid=0, ex_valid=0, state=RUN, flush=0, branch_taken=0.
- Reset mid-operation: immediate, regardless of stall or state.
- Redirect condition (combinational, drives branch_taken): ex_valid & ~stall & ((opcode_ex==JUMP) | (opcode_ex==BRA & rs1_value==rs2_value)).
  - Equality is a full 32-bit unsigned compare.
  - Any other opcode never redirects.
- Each rising edge with stall=0:
  - pc_id<=pc; pc_delay<=pc_id.
  - No redirect: pc<=pc+PC_INC, wrapping modulo 2^PC_WIDTH with no flag. id_valid<=1; ex_valid<=id_valid.
  - Redirect: pc<=target_addr; id_valid<=0; ex_valid<=0.
- stall=1: all registers hold; branch_taken is forced 0.
  - A redirect pending in EX is evaluated once stall drops; operands are sampled then.
- FSM, states RUN and FLUSH, with a 2-bit squash counter:
  - RUN→FLUSH on redirect; counter<=2.
  - In FLUSH, each unstalled cycle decrements the counter. Leave for RUN when it reaches 0 (decrement from 1).
  - flush=1 iff state==FLUSH.
  - Redirects cannot occur in FLUSH because ex_valid=0 there.
- Timing: redirect decided in cycle t → pc=target at t+1 → target instruction in EX with ex_valid=1 at t+3. Cycles t+1 and t+2 show ex_valid=0 and flush=1.
- After reset, ex_valid first rises on the 2nd unstalled edge. The instruction at RESET_PC is then in EX.
- target_addr is taken as-is; sign extension is done upstream. Misaligned targets are not checked.

Optional Feature:
- Macro BRANCH_NE_EN.
- Defined: adds opcode BNE = 6'b010111, which redirects when ex_valid & ~stall & rs1_value!=rs2_value. Redirect, flush and timing are identical to BRA.
  - branch_program must compute pc_delay+imm for BNE as it does for BRA.
- Not defined: 6'b010111 is treated as a non-branch opcode.

Test Plan:
- Reset release with stall=0, no branches → pc sequence 0,4,8,12. pc_delay=0 with ex_valid=1 on the 2nd edge, then 4, 8.
- pc_delay=0x8 in EX, opcode_ex=JUMP, target_addr=0x100 → branch_taken=1 that cycle. Next cycle pc=0x100, flush=1 for 2 cycles, ex_valid=0 for 2 cycles. Then pc_delay=0x100 with ex_valid=1.
- opcode_ex=BRA, rs1=rs2=0x5, target=0x40 → redirect to 0x40. Repeat with rs1=0x5, rs2=0x6 → no redirect, pc continues +4, flush stays 0.
- BRA taken held with stall=1 for 3 cycles → pc, pc_delay and state frozen, branch_taken=0. Stall drops → branch_taken=1, pc=target next cycle.
- Assert reset during FLUSH (counter=1), asynchronously mid-cycle → outputs return to reset values immediately, state=RUN. After release, fetch resumes at RESET_PC.
- pc=0xFFFF_FFFC, no branch → next pc=0x0000_0000. With BRANCH_NE_EN defined: opcode 6'b010111, rs1=1, rs2=2 → redirect. Without the macro → no redirect.
